// File: rtl/axi_rd_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_burst_master
// Summary  : Splits one user read request into boundary-safe AXI read bursts
//            with bounded outstanding ARs, length-based beat counting and
//            RLAST checking.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_burst_master #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12,
    parameter int MAX_BURST  = 16,
    parameter int BOUND_BITS = 10,
    parameter int MAX_OUTS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_end,
    input  logic                  rd_trig,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [LEN_WIDTH-1:0]  rd_len,
    output logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    input  logic                  rd_data_ready,
    output logic                  rd_done,
    output logic                  rd_err,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [7:0]            axi_arlen,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic                  axi_rlast
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_AR   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [BOUND_BITS:0] c_bound_span = (BOUND_BITS+1)'(1) << BOUND_BITS;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [LEN_WIDTH-1:0]  ar_left_q, ar_left_d;
    logic [LEN_WIDTH-1:0]  beat_left_q, beat_left_d;
    logic [8:0]            blen_q, blen_d;
    logic [8:0]            burst_cnt_q, burst_cnt_d;
    logic [2:0]            outs_cnt_q, outs_cnt_d;
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [8:0]            fifo_q [4];
    logic [8:0]            fifo_d [4];
    logic                  rd_err_q, rd_err_d;

    logic                  w_start, w_ar_hs, w_r_hs, w_burst_end, w_fifo_empty, w_beats_pending;
    logic [8:0]            w_head, w_burst_cnt_inc, w_cap, w_blen;
    logic [BOUND_BITS:0]   w_room;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (32'(p) == MAX_OUTS - 1) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_start         = (state_q == S_IDLE) && rd_trig && init_end;
    assign w_ar_hs         = axi_arvalid && axi_arready;
    assign w_fifo_empty    = (outs_cnt_q == 3'd0);
    assign w_beats_pending = (beat_left_q != '0) && !w_fifo_empty;
    assign w_head          = fifo_q[rd_ptr_q];
    assign w_burst_cnt_inc = burst_cnt_q + 9'd1;
    assign w_burst_end     = (w_burst_cnt_inc == w_head);
    assign w_r_hs          = axi_rvalid && axi_rready;

    // Burst length: smallest of remaining beats, MAX_BURST and room to the boundary
    assign w_cap  = (ar_left_q > LEN_WIDTH'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(ar_left_q);
    assign w_room = c_bound_span - {1'b0, next_addr_q[BOUND_BITS-1:0]};
    assign w_blen = (32'(w_room) < 32'(w_cap)) ? 9'(w_room) : w_cap;

    assign axi_rready    = rd_data_ready && w_beats_pending;
    assign rd_data_valid = axi_rvalid && w_beats_pending;
    assign rd_data       = axi_rdata;
    assign rd_err        = rd_err_q;
    assign axi_araddr    = next_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (w_start) state_d = (rd_len == '0) ? S_DONE : S_CALC;
            S_CALC: state_d = S_AR;
            S_AR:   if (w_ar_hs) state_d = (ar_left_q == LEN_WIDTH'(blen_q)) ? S_WAIT : S_CALC;
            S_WAIT: if (beat_left_q == '0) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_ready    = (state_q == S_IDLE) && init_end;
        axi_arvalid = (state_q == S_AR) && (32'(outs_cnt_q) < MAX_OUTS);
        axi_arlen   = (state_q == S_AR) ? (blen_q[7:0] - 8'd1) : 8'd0;
        rd_done     = (state_q == S_DONE);
    end

    always_comb begin
        next_addr_d = next_addr_q;
        ar_left_d   = ar_left_q;
        beat_left_d = beat_left_q;
        blen_d      = blen_q;
        burst_cnt_d = burst_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_d      = fifo_q;
        rd_err_d    = rd_err_q;

        if (w_start) begin
            next_addr_d = rd_addr;
            ar_left_d   = rd_len;
            beat_left_d = rd_len;
            rd_err_d    = 1'b0;
        end
        if (state_q == S_CALC) begin
            blen_d = w_blen;
        end
        if (w_ar_hs) begin
            fifo_d[wr_ptr_q] = blen_q;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
            next_addr_d      = next_addr_q + ADDR_WIDTH'(blen_q);
            ar_left_d        = ar_left_q - LEN_WIDTH'(blen_q);
        end
        // Beat counting is purely length-based; RLAST only feeds the error flag
        if (w_r_hs) begin
            beat_left_d = beat_left_q - LEN_WIDTH'(1);
            if (w_burst_end) begin
                burst_cnt_d = 9'd0;
                rd_ptr_d    = ptr_inc(rd_ptr_q);
            end else begin
                burst_cnt_d = w_burst_cnt_inc;
            end
            if (axi_rlast != w_burst_end) begin
                rd_err_d = 1'b1;
            end
        end
        outs_cnt_d = outs_cnt_q + {2'b00, w_ar_hs} - {2'b00, w_r_hs && w_burst_end};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_addr_q <= '0;
            ar_left_q   <= '0;
            beat_left_q <= '0;
            blen_q      <= '0;
            burst_cnt_q <= '0;
            outs_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_err_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            next_addr_q <= next_addr_d;
            ar_left_q   <= ar_left_d;
            beat_left_q <= beat_left_d;
            blen_q      <= blen_d;
            burst_cnt_q <= burst_cnt_d;
            outs_cnt_q  <= outs_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_err_q    <= rd_err_d;
            fifo_q      <= fifo_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_burst_master
// Summary  : Directed self-checking bench with a simple AXI read slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_burst_master;

    logic        clk = 1'b0;
    logic        rst, init_end, rd_trig, rd_data_ready, axi_arready;
    logic [25:0] rd_addr;
    logic [11:0] rd_len;
    logic        rd_ready, rd_data_valid, rd_done, rd_err;
    logic [31:0] rd_data;
    logic        axi_arvalid, axi_rready;
    logic [25:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic        axi_rvalid = 1'b0;
    logic        axi_rlast  = 1'b0;
    logic [31:0] axi_rdata  = 32'h0;

    always #5 clk = ~clk;

    axi_rd_burst_master dut (
        .clk(clk), .rst(rst), .init_end(init_end), .rd_trig(rd_trig),
        .rd_addr(rd_addr), .rd_len(rd_len), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
        .rd_done(rd_done), .rd_err(rd_err),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arlen(axi_arlen), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_rdata(axi_rdata), .axi_rlast(axi_rlast)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model and monitors (single writer for all logged state)
    logic [25:0] q_addr[$];
    logic [7:0]  q_len[$];
    int          q_t[$];
    int          cyc = 0, beat_i = 0;
    int          r_delay = 0, corrupt_idx = -1;
    int          ar_n = 0, rx_n = 0, done_n = 0, data_err = 0;
    logic [25:0] ar_addr_log [64];
    logic [7:0]  ar_len_log  [64];
    int          ar_rx_log   [64];
    int          ar_outs_log [64];
    logic [25:0] exp_base = '0;
    int          rx_base = 0, ar_base = 0, done_base = 0, data_base = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_addr.delete(); q_len.delete(); q_t.delete();
            beat_i = 0;
            axi_rvalid <= 1'b0;
            axi_rlast  <= 1'b0;
        end else begin
            cyc++;
            if (rd_done) done_n++;
            if (rd_data_valid && rd_data_ready) begin
                if (rd_data !== (32'hA000_0000 | 32'(exp_base + 26'(rx_n - rx_base)))) data_err++;
                rx_n++;
            end
            if (axi_rvalid && axi_rready && q_addr.size() > 0) begin
                if (beat_i == int'(q_len[0])) begin
                    void'(q_addr.pop_front()); void'(q_len.pop_front()); void'(q_t.pop_front());
                    beat_i = 0;
                end else begin
                    beat_i++;
                end
            end
            if (axi_arvalid && axi_arready) begin
                q_addr.push_back(axi_araddr); q_len.push_back(axi_arlen); q_t.push_back(cyc);
                if (ar_n < 64) begin
                    ar_addr_log[ar_n] = axi_araddr;
                    ar_len_log[ar_n]  = axi_arlen;
                    ar_rx_log[ar_n]   = rx_n - rx_base;
                    ar_outs_log[ar_n] = q_addr.size();
                end
                ar_n++;
            end
            if (q_addr.size() > 0 && (cyc - q_t[0]) >= r_delay) begin
                axi_rvalid <= 1'b1;
                axi_rdata  <= 32'hA000_0000 | 32'(q_addr[0] + 26'(beat_i));
                axi_rlast  <= (beat_i == int'(q_len[0])) || (beat_i == corrupt_idx);
            end else begin
                axi_rvalid <= 1'b0;
                axi_rlast  <= 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [25:0] a, input logic [11:0] l);
        int k;
        k = 0;
        while (!rd_ready && k < 200) begin @(negedge clk); k++; end
        check_eq("rd_ready_before_trig", rd_ready, 1);
        exp_base  = a;
        rx_base   = rx_n;
        ar_base   = ar_n;
        done_base = done_n;
        data_base = data_err;
        rd_addr = a; rd_len = l; rd_trig = 1'b1;
        @(negedge clk);
        rd_trig = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done_n == done_base && k < 3000) begin @(negedge clk); k++; end
        check_eq({tag, "_timeout"}, (k < 3000), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_req(input string tag, input int n_ar, input int n_beats);
        check_eq({tag, "_ar_count"}, ar_n - ar_base, n_ar);
        check_eq({tag, "_beats"}, rx_n - rx_base, n_beats);
        check_eq({tag, "_data_err"}, data_err - data_base, 0);
        check_eq({tag, "_done_pulses"}, done_n - done_base, 1);
    endtask

    task automatic check_ar(input string tag, input int idx, input logic [25:0] a, input logic [7:0] l);
        check_eq({tag, "_araddr"}, ar_addr_log[ar_base + idx], a);
        check_eq({tag, "_arlen"}, ar_len_log[ar_base + idx], l);
    endtask

    initial begin
        int k, mirror_err, max_outs;
        rst = 1'b1; init_end = 1'b0; rd_trig = 1'b0; rd_addr = '0; rd_len = '0;
        rd_data_ready = 1'b1; axi_arready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_arvalid", axi_arvalid, 0);
        check_eq("rst_araddr", axi_araddr, 0);
        check_eq("rst_arlen", axi_arlen, 0);
        check_eq("rst_rd_done", rd_done, 0);
        check_eq("rst_rd_err", rd_err, 0);
        check_eq("rst_rd_ready_init_low", rd_ready, 0);
        init_end = 1'b1;
        #1 check_eq("rst_rd_ready_init_high", rd_ready, 1);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Single burst
        start_req(26'h100, 12'd8);
        wait_done("single");
        check_req("single", 1, 8);
        check_ar("single0", 0, 26'h100, 8'd7);
        check_eq("single_rd_err", rd_err, 0);

        // Split into MAX_BURST pieces
        start_req(26'h0, 12'd40);
        wait_done("split");
        check_req("split", 3, 40);
        check_ar("split0", 0, 26'h000, 8'd15);
        check_ar("split1", 1, 26'h010, 8'd15);
        check_ar("split2", 2, 26'h020, 8'd7);

        // Boundary at 0x400
        start_req(26'h3FA, 12'd20);
        wait_done("bound");
        check_req("bound", 2, 20);
        check_ar("bound0", 0, 26'h3FA, 8'd5);
        check_ar("bound1", 1, 26'h400, 8'd13);

        // Outstanding limit with delayed read data
        r_delay = 20;
        start_req(26'h200, 12'd64);
        wait_done("outs");
        r_delay = 0;
        check_req("outs", 4, 64);
        check_eq("outs_ar1_before_data", ar_rx_log[ar_base + 1], 0);
        check_eq("outs_ar2_after_burst0", (ar_rx_log[ar_base + 2] >= 16), 1);
        max_outs = 0;
        for (int i = 0; i < 4; i++) if (ar_outs_log[ar_base + i] > max_outs) max_outs = ar_outs_log[ar_base + i];
        check_eq("outs_max_in_flight", max_outs, 2);
        check_ar("outs3", 3, 26'h230, 8'd15);

        // Toggling user backpressure
        mirror_err = 0;
        start_req(26'h50, 12'd24);
        k = 0;
        while (done_n == done_base && k < 3000) begin
            @(negedge clk);
            rd_data_ready = ~rd_data_ready;
            #1;
            if (axi_rready && !rd_data_ready) mirror_err++;
            if (rd_data_valid && (axi_rready != rd_data_ready)) mirror_err++;
            k++;
        end
        rd_data_ready = 1'b1;
        check_eq("bp_timeout", (k < 3000), 1);
        repeat (4) @(negedge clk);
        check_eq("bp_rready_mirror", mirror_err, 0);
        check_eq("bp_beats", rx_n - rx_base, 24);
        check_eq("bp_data_err", data_err - data_base, 0);
        check_eq("bp_rd_err", rd_err, 0);

        // Early RLAST on beat 4 of 8
        corrupt_idx = 3;
        start_req(26'h80, 12'd8);
        wait_done("rlast");
        corrupt_idx = -1;
        check_req("rlast", 1, 8);
        check_eq("rlast_rd_err", rd_err, 1);

        // Zero-length request clears the error and issues no AR
        start_req(26'h90, 12'd0);
        check_eq("zero_err_cleared", rd_err, 0);
        wait_done("zero");
        check_req("zero", 0, 0);

        // Reset in the middle of a burst
        r_delay = 20;
        start_req(26'h300, 12'd64);
        k = 0;
        while ((rx_n - rx_base) < 3 && k < 500) begin @(negedge clk); k++; end
        check_eq("midrst_reached_data", (k < 500), 1);
        rst = 1'b1;
        #1;
        check_eq("midrst_arvalid", axi_arvalid, 0);
        check_eq("midrst_rd_ready", rd_ready, 1);
        check_eq("midrst_rready", axi_rready, 0);
        check_eq("midrst_rd_data_valid", rd_data_valid, 0);
        @(negedge clk); rst = 1'b0; r_delay = 0;
        @(negedge clk);

        // Recovery after reset
        start_req(26'h10, 12'd4);
        wait_done("recover");
        check_req("recover", 1, 4);
        check_ar("recover0", 0, 26'h010, 8'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/axi_rd_burst_master.md
Name: axi_rd_burst_master

Overview:
Parametrised successor to the single-burst AXI read master. It accepts one read request of up to 2^LEN_WIDTH-1 beats and splits it into AXI bursts of at most MAX_BURST beats. No burst crosses a 2^BOUND_BITS-beat (DDR row/column) boundary. Up to MAX_OUTS address requests may be in flight ahead of returning data. Read data is passed to the user with valid/ready backpressure, and each burst's length and RLAST are checked. It sits between user logic (frame/line readers) and the DDR2 controller AXI slave port.

Parameters:
ADDR_WIDTH, 26, beat-granular address width (one address unit = one DATA_WIDTH beat)
DATA_WIDTH, 32, AXI read data width
LEN_WIDTH, 12, width of total request length in beats
MAX_BURST, 16, maximum beats per AXI burst, legal 1..256
BOUND_BITS, 10, bursts never cross an address multiple of 2^BOUND_BITS (match COL_BITS)
MAX_OUTS, 2, maximum issued-but-incomplete bursts, legal 1..4

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
init_end  in  1  DDR initialisation complete; requests ignored while low
rd_trig  in  1  request strobe, sampled only when rd_ready=1
rd_addr  in  ADDR_WIDTH  start beat address, captured with rd_trig
rd_len  in  LEN_WIDTH  total beats, captured with rd_trig
rd_ready  out  1  block idle and init_end high
rd_data  out  DATA_WIDTH  read beat (= axi_rdata)
rd_data_valid  out  1  beat valid
rd_data_ready  in  1  user accepts beat
rd_done  out  1  one-cycle pulse when the request completes
rd_err  out  1  sticky RLAST mismatch flag, cleared by next accepted rd_trig
axi_arvalid  out  1  AR valid
axi_arready  in  1  AR ready
axi_araddr  out  ADDR_WIDTH  burst start address
axi_arlen  out  8  burst beats minus 1 (AXI encoding)
axi_rvalid  in  1  R valid
axi_rready  out  1  R ready
axi_rdata  in  DATA_WIDTH  R data
axi_rlast  in  1  R last beat of burst

Behaviour:
- Reset (async assert, sync release): FSM=IDLE. All counters and the length FIFO are cleared. axi_arvalid=0, axi_araddr=0, axi_arlen=0, rd_done=0, rd_err=0. rd_ready follows init_end.
- Reset mid-operation abandons in-flight bursts. The AXI slave must be reset together with this block.
- FSM states: IDLE, CALC, AR, WAIT, DONE.
- IDLE: rd_ready=init_end. If rd_trig & init_end:
  - Capture next_addr=rd_addr, ar_left=rd_len, beat_left=rd_len; clear rd_err.
  - Go to CALC, or to DONE if rd_len=0 (no AR issued).
- CALC (1 cycle): blen = min(ar_left, MAX_BURST, 2^BOUND_BITS - next_addr[BOUND_BITS-1:0]). Register blen, then go to AR.
- AR:
  - Assert axi_arvalid only when outs_cnt < MAX_OUTS. axi_araddr=next_addr, axi_arlen=blen-1.
  - axi_araddr and axi_arlen stay stable while axi_arvalid=1 && !axi_arready.
  - On handshake: push blen into the length FIFO (depth MAX_OUTS), outs_cnt+1, next_addr+=blen, ar_left-=blen, arvalid drops next cycle.
  - Then go to CALC if ar_left≠0, else to WAIT.
- WAIT: remain until beat_left=0, then go to DONE.
- DONE: rd_done=1 for one cycle, then go to IDLE.
- R channel is independent of the AR FSM:
  - axi_rready = rd_data_ready && beat_left≠0 && FIFO non-empty.
  - rd_data_valid = axi_rvalid && beat_left≠0 && FIFO non-empty.
  - rd_data = axi_rdata (combinational pass-through, zero latency).
- Beat accepted (axi_rvalid && axi_rready):
  - beat_left-1 and burst_cnt+1.
  - When burst_cnt+1 = FIFO head: pop FIFO, outs_cnt-1, burst_cnt=0.
  - If axi_rlast differs from (burst_cnt+1 = head), set rd_err. Counting stays length-based; RLAST never changes the beat count.
- Simultaneous AR handshake and final-beat pop in one cycle: outs_cnt unchanged, FIFO push and pop both take effect.
- Address arithmetic wraps modulo 2^ADDR_WIDTH, with no error.
- Arithmetic widths:
  - blen is 9 bits, to hold 256.
  - Boundary term is BOUND_BITS+1 bits.
  - ar_left and beat_left are LEN_WIDTH bits.
- rd_trig outside IDLE is ignored.
- axi_rvalid while beat_left=0 is not accepted (axi_rready=0).

Test Plan:
- Single burst: addr=0x100, len=8, always-ready slave -> one AR (araddr=0x100, arlen=7); 8 beats on rd_data in order; rd_done 1 cycle after the 8th beat; rd_err=0.
- Split: len=40, MAX_BURST=16, addr=0x0 -> ARs (0x0,15),(0x10,15),(0x20,7); 40 beats; one rd_done.
- Boundary: addr=0x3FA, len=20 -> ARs (0x3FA,5),(0x400,13); no burst crosses 0x400.
- Outstanding limit: MAX_OUTS=2, arready=1, slave delays R by 20 cycles, len=64 -> exactly 2 ARs before the first beat; 3rd AR only after the first burst's last beat.
- Backpressure/error: rd_data_ready toggles every cycle -> axi_rready mirrors it, no beat lost or duplicated. Slave asserts rlast on beat 4 of an 8-beat burst -> rd_err=1 and 8 beats still counted. Next rd_trig clears rd_err.
- Edge/reset: rd_len=0 -> rd_done pulse, no AR. rst asserted during a burst -> axi_arvalid=0, rd_ready=1 (init_end high), FIFO empty immediately.
